// File: rtl/ofdm_frame_slicer_if.sv
// Stream bundle for the OFDM frame slicer: sample input with SOF strobe and
// packetised output with frame-level SOF/EOF markers.
interface ofdm_frame_slicer_if #(
    parameter int WIDTH = 32
);
    // Upstream (sync detector) side
    logic [WIDTH-1:0] i_tdata;
    logic             i_sof;
    logic             i_tvalid;
    logic             i_tready;

    // Downstream (demodulator) side
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;
    logic             o_sof;
    logic             o_eof;

    // Environment around the slicer: produces samples, consumes packets
    modport master (
        output i_tdata, i_sof, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tvalid, o_sof, o_eof
    );

    // The slicer itself
    modport slave (
        input  i_tdata, i_sof, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tvalid, o_sof, o_eof
    );
endinterface

// File: rtl/ofdm_frame_slicer.sv
// OFDM frame slicer: follows the sync detector, optionally forwards the
// preamble, strips or keeps the cyclic prefix of each data symbol and emits
// one packet per symbol with frame-level SOF/EOF markers. Zero-latency
// datapath; only control and counters are registered.
module ofdm_frame_slicer #(
    parameter int WIDTH           = 32,
    parameter int SYMBOL_LEN      = 64,
    parameter int CP_LEN          = 16,
    parameter int PREAMBLE_LEN    = 160,
    parameter int MAX_NUM_SYMBOLS = 200,
    localparam int NSYM_W         = $clog2(MAX_NUM_SYMBOLS + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [NSYM_W-1:0]     num_symbols,
    input  logic                  num_symbols_valid,
    input  logic                  force_num_symbols_valid,
    input  logic                  keep_cp,
    input  logic                  pass_preamble,
    ofdm_frame_slicer_if.slave    strm,
    output logic                  frame_active,
    output logic [31:0]           frame_cnt,
    output logic [15:0]           sof_ignored_cnt
);

    // Sample counter must cover the longest segment of the frame.
    localparam int LEN_PS  = (PREAMBLE_LEN > SYMBOL_LEN) ? PREAMBLE_LEN : SYMBOL_LEN;
    localparam int MAX_LEN = (LEN_PS > CP_LEN) ? LEN_PS : CP_LEN;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0]  CP_LAST  = CNT_W'((CP_LEN > 0) ? CP_LEN - 1 : 0);
    localparam logic [CNT_W-1:0]  SYM_LAST = CNT_W'(SYMBOL_LEN - 1);
    localparam logic [NSYM_W-1:0] NSYM_MAX = NSYM_W'(MAX_NUM_SYMBOLS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_CP,
        S_SYM
    } state_t;

    // Registered state
    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;      // sample index within segment
    logic [NSYM_W-1:0]  sym_q,      sym_d;      // data symbol index in frame
    logic [NSYM_W-1:0]  nsym_q,     nsym_d;     // symbols in current frame
    logic               arm_q,      arm_d;      // num_symbols armed for next frame
    logic               keep_q,     keep_d;     // keep_cp latched at frame start
    logic               pass_q,     pass_d;     // pass_preamble latched at frame start
    logic               pend_q,     pend_d;     // o_sof still owed to this frame
    logic [31:0]        fcnt_q,     fcnt_d;
    logic [15:0]        ign_q,      ign_d;

    // Combinational decode
    logic               sof_start;
    state_t             eff_state;
    logic               cur_pass;
    logic               load_nsym;
    logic [NSYM_W-1:0]  nsym_clamp;
    logic [NSYM_W-1:0]  cur_nsym;
    logic               fwd_raw;
    logic               fwd;
    logic               in_ready;
    logic               out_valid;
    logic               beat;
    logic               last_pre;
    logic               last_cp;
    logic               last_sym;
    logic               final_sym;

    // The SOF beat itself is preamble sample 0, so while IDLE a valid SOF
    // makes this cycle behave as the first PRE cycle using live config.
    assign sof_start  = (state_q == S_IDLE) && strm.i_tvalid && strm.i_sof;
    assign eff_state  = sof_start ? S_PRE : state_q;
    assign cur_pass   = (state_q == S_IDLE) ? pass_preamble : pass_q;

    // A pulse on the frame-start cycle counts as armed for that frame.
    assign load_nsym  = arm_q | num_symbols_valid | force_num_symbols_valid;
    assign nsym_clamp = (num_symbols > NSYM_MAX) ? NSYM_MAX : num_symbols;
    assign cur_nsym   = ((state_q == S_IDLE) && load_nsym) ? nsym_clamp : nsym_q;

    // Forwarding segments pass the handshake through; the rest are sunk.
    assign fwd_raw    = (eff_state == S_PRE) ? cur_pass :
                        (eff_state == S_CP)  ? keep_q   :
                        (eff_state == S_SYM);
    assign fwd        = fwd_raw & reset_n & ~clear;

    assign in_ready   = fwd ? strm.o_tready : 1'b1;
    assign out_valid  = fwd & strm.i_tvalid;
    assign beat       = strm.i_tvalid & in_ready;

    assign last_pre   = (eff_state == S_PRE) && (cnt_q == PRE_LAST);
    assign last_cp    = (eff_state == S_CP)  && (cnt_q == CP_LAST);
    assign last_sym   = (eff_state == S_SYM) && (cnt_q == SYM_LAST);
    assign final_sym  = last_sym && ((sym_q + NSYM_W'(1)) == nsym_q);

    assign strm.i_tready = in_ready;
    assign strm.o_tdata  = strm.i_tdata;
    assign strm.o_tvalid = out_valid;
    assign strm.o_tlast  = out_valid & (last_pre | last_sym);
    assign strm.o_eof    = out_valid & ((last_pre && (cur_nsym == '0)) | final_sym);
    assign strm.o_sof    = out_valid & (sof_start | pend_q);

    assign frame_active    = (state_q != S_IDLE);
    assign frame_cnt       = fcnt_q;
    assign sof_ignored_cnt = ign_q;

    // Next-state, counter and configuration-latch logic
    always_comb begin
        // NOTE: every target gets a hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        sym_d   = sym_q;
        nsym_d  = nsym_q;
        arm_d   = arm_q;
        keep_d  = keep_q;
        pass_d  = pass_q;
        pend_d  = pend_q;
        fcnt_d  = fcnt_q;
        ign_d   = ign_q;

        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sym_d   = '0;
            nsym_d  = NSYM_MAX;
            arm_d   = 1'b0;
            keep_d  = 1'b0;
            pass_d  = 1'b0;
            pend_d  = 1'b0;
            fcnt_d  = '0;
            ign_d   = '0;
        end else begin
            if (num_symbols_valid) begin
                arm_d = 1'b1;
            end

            if (beat) begin
                if (strm.i_sof && (state_q != S_IDLE) && (ign_q != 16'hFFFF)) begin
                    ign_d = ign_q + 16'd1;
                end

                if (out_valid) begin
                    pend_d = 1'b0;
                end

                if (sof_start) begin
                    keep_d = keep_cp;
                    pass_d = pass_preamble;
                    nsym_d = cur_nsym;
                    arm_d  = 1'b0;
                    fcnt_d = fcnt_q + 32'd1;
                    // If the SOF beat is not forwarded, the first forwarded beat carries o_sof.
                    pend_d = ~pass_preamble;
                end

                unique case (eff_state)
                    S_PRE: begin
                        if (last_pre) begin
                            cnt_d = '0;
                            sym_d = '0;
                            if (cur_nsym == '0) begin
                                state_d = S_IDLE;
                                pend_d  = 1'b0;
                            end else begin
                                state_d = (CP_LEN == 0) ? S_SYM : S_CP;
                            end
                        end else begin
                            state_d = S_PRE;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                    S_CP: begin
                        if (last_cp) begin
                            state_d = S_SYM;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                    S_SYM: begin
                        if (last_sym) begin
                            cnt_d = '0;
                            if (final_sym) begin
                                state_d = S_IDLE;
                                sym_d   = '0;
                                pend_d  = 1'b0;
                            end else begin
                                state_d = (CP_LEN == 0) ? S_SYM : S_CP;
                                sym_d   = sym_q + NSYM_W'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State and counter registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sym_q   <= '0;
            nsym_q  <= NSYM_MAX;
            arm_q   <= 1'b0;
            keep_q  <= 1'b0;
            pass_q  <= 1'b0;
            pend_q  <= 1'b0;
            fcnt_q  <= '0;
            ign_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            nsym_q  <= nsym_d;
            arm_q   <= arm_d;
            keep_q  <= keep_d;
            pass_q  <= pass_d;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
            ign_q   <= ign_d;
        end
    end

endmodule

// File: doc/ofdm_frame_slicer.md
Name: ofdm_frame_slicer

Overview:
Parametrised successor to the fixed-geometry OFDM sync stage. It follows the sync detector and takes a sample stream carrying a start-of-frame strobe. It optionally forwards the preamble, strips (or keeps) the cyclic prefix of each data symbol, and emits one packet per symbol with frame-level SOF/EOF markers. Symbol length, CP length, preamble length, sample width and maximum symbol count are generic, and frame shape can be reconfigured at run time without reset.

Parameters:
WIDTH, 32, sample width in bits (complex IQ packed).
SYMBOL_LEN, 64, useful samples per OFDM symbol, >=2.
CP_LEN, 16, cyclic prefix samples per symbol, >=0.
PREAMBLE_LEN, 160, preamble samples following the SOF strobe, >=1.
MAX_NUM_SYMBOLS, 200, upper clamp on data symbols per frame; NSYM_W = $clog2(MAX_NUM_SYMBOLS+1).

Ports:
clk  in  1  single clock domain
reset_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous abort; returns to IDLE and zeroes counters
num_symbols  in  NSYM_W  data symbols per frame
num_symbols_valid  in  1  one-cycle pulse; arms num_symbols for next frame
force_num_symbols_valid  in  1  level; num_symbols is reloaded at every frame start
keep_cp  in  1  1 = forward CP samples as part of each symbol
pass_preamble  in  1  1 = forward preamble as its own packet
i_tdata  in  WIDTH  input sample
i_sof  in  1  first preamble sample marker, qualified by i_tvalid
i_tvalid / i_tready  in / out  1  input handshake
o_tdata  out  WIDTH  output sample
o_tlast  out  1  last sample of each output packet
o_tvalid / o_tready  out / in  1  output handshake
o_sof  out  1  first forwarded sample of a frame
o_eof  out  1  last sample of last symbol of a frame
frame_active  out  1  high in every state but IDLE
frame_cnt  out  32  frames started, wraps
sof_ignored_cnt  out  16  SOF strobes seen while frame_active, saturates at 0xFFFF

Behaviour:
- Reset (reset_n low, async) and clear: state=IDLE, all counters 0, arm flag 0, latched nsym=MAX_NUM_SYMBOLS, keep/pass latches 0. Outputs o_tvalid=o_tlast=o_sof=o_eof=frame_active=0.
- Datapath is zero latency. o_tdata=i_tdata. In forwarding states, o_tvalid=i_tvalid and i_tready=o_tready. In discarding states (IDLE, drop-preamble, drop-CP), i_tready=1 and o_tvalid=0.
- A beat is a cycle with i_tvalid & i_tready. All counters advance only on beats. i_tlast is ignored.
- Arm flag: set by a num_symbols_valid pulse. It is consumed at frame start. A pulse coinciding with frame start is used by that frame.
- Frame start (IDLE beat with i_sof=1):
  - Latch keep_cp and pass_preamble.
  - If arm flag or force_num_symbols_valid is set, latch nsym=min(num_symbols, MAX_NUM_SYMBOLS); clear the arm flag.
  - frame_cnt++.
  - The SOF beat is preamble sample 0.
- States and transitions:
  - IDLE -> PRE on SOF beat.
  - PRE: count PREAMBLE_LEN beats. Forward only if pass_preamble; the last preamble beat has o_tlast=1.
  - End of PRE -> CP, or -> SYM when CP_LEN=0. If nsym=0: -> IDLE, and o_eof is asserted with the preamble tlast when the preamble is forwarded.
  - CP: count CP_LEN beats. Forwarded only if keep_cp, then -> SYM.
  - SYM: count SYMBOL_LEN beats, all forwarded. Last beat has o_tlast=1. Symbol index++. If index==nsym, o_eof=1 and -> IDLE; else -> CP.
- o_sof is asserted on the first forwarded beat of the frame:
  - preamble sample 0, if pass_preamble;
  - otherwise the first CP sample of symbol 0, if keep_cp;
  - otherwise the first sample of symbol 0.
- When keep_cp=1, each packet is CP_LEN+SYMBOL_LEN long, with tlast on the final useful sample.
- i_sof while not IDLE: ignored for framing, sof_ignored_cnt++ (saturating). The next frame starts only on an SOF seen in IDLE. A beat that ends a frame and carries i_sof is counted as ignored.
- Config changes (keep_cp, pass_preamble, num_symbols) mid-frame do not affect the current frame.
- clear mid-frame: the current cycle's beat is not forwarded, and there is no tlast/eof for the truncated frame.
- Output sideband signals are asserted only while o_tvalid=1 and held stable under backpressure.

Test Plan:
- Defaults, keep_cp=0, pass_preamble=0, num_symbols=3 pulsed, SOF then 400 ramp samples:
  - 3 packets of 64 samples each: values 176..239, 256..319, 336..399 (SOF sample = 0);
  - o_sof on sample 176, o_eof on 399; frame_cnt=1.
- keep_cp=1, pass_preamble=1, nsym=2: packets of 160, 80 and 80 samples; o_sof on the first preamble sample; o_eof on the last of the third packet.
- Random o_tready (50%) and i_tvalid gaps on the first case: identical output sequence, no lost or duplicated beats, sideband stable while stalled.
- Second SOF at sample 50 inside a frame: ignored, sof_ignored_cnt=1, framing unchanged. num_symbols=250 -> 200 symbols emitted. num_symbols=0 with pass_preamble=1 -> single 160-sample packet with tlast and eof.
- force_num_symbols_valid=1 with num_symbols changed 2->4 between frames: second frame has 4 symbols. Without force and without a pulse: the old value is reused.
- reset_n low mid-SYM: o_tvalid drops asynchronously. After release: IDLE, counters 0, no output until the next SOF. clear mid-frame: same, synchronously.
